// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO, first-word-fall-through, optional overrun flag (UART_RX_FIFO_OVERRUN_EN)
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  pop,
    output logic [7:0]            rd_data,
    output logic                  data_avail,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  clr_ovr,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  push_ok;
    logic                  pop_ok;

    // Status comes only from the registered count, so in_valid/pop never reach it combinationally.
    assign full       = (cnt_q == CNT_FULL);
    assign data_avail = (cnt_q != '0);
    assign in_ready   = !full;
    assign count      = cnt_q;

    assign push_ok = in_valid && !full;
    assign pop_ok  = pop && data_avail;

    assign rd_data = data_avail ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic ovr_q;

    // A dropped byte outranks a simultaneous clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (in_valid && full) begin
            ovr_q <= 1'b1;
        end else if (clr_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_clr_ovr;

    assign unused_clr_ovr = clr_ovr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model
`timescale 1ns/1ps
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pop;
    logic [7:0] rd_data;
    logic       data_avail;
    logic       full;
    logic [4:0] count;
    logic       clr_ovr;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         m_ovr;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       pp;
        logic       cl;
        int         ecnt;
        logic [7:0] erd;
    } vec_t;
    vec_t vt[6];

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pop(pop), .rd_data(rd_data), .data_avail(data_avail),
        .full(full), .count(count), .clr_ovr(clr_ovr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int         n;
        logic [7:0] head;
        n    = mq.size();
        head = (n > 0) ? mq[0] : 8'h00;
        chk({tag, ".count"},      int'(count),      n);
        chk({tag, ".full"},       int'(full),       int'(n == DEPTH));
        chk({tag, ".in_ready"},   int'(in_ready),   int'(n != DEPTH));
        chk({tag, ".data_avail"}, int'(data_avail), int'(n != 0));
        chk({tag, ".rd_data"},    int'(rd_data),    int'(head));
        chk({tag, ".overrun"},    int'(overrun),    int'(m_ovr));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic iv, input logic [7:0] d, input logic pp, input logic cl, input string tag);
        bit was_full, was_empty;
        in_valid = iv; in_data = d; pop = pp; clr_ovr = cl;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        @(posedge clk);
        #1;
        if (pp && !was_empty) void'(mq.pop_front());
        if (iv && !was_full)  mq.push_back(d);
        if (OVR_EN) begin
            if (iv && was_full) m_ovr = 1'b1;
            else if (cl)        m_ovr = 1'b0;
        end
        in_valid = 1'b0; pop = 1'b0; clr_ovr = 1'b0;
        chk_model(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".data_avail"}, int'(data_avail), 0);
        chk({tag, ".full"},       int'(full),       0);
        chk({tag, ".in_ready"},   int'(in_ready),   1);
        chk({tag, ".count"},      int'(count),      0);
        chk({tag, ".rd_data"},    int'(rd_data),    0);
        chk({tag, ".overrun"},    int'(overrun),    0);
    endtask

    initial begin
        bit seen55;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; pop = 1'b0; clr_ovr = 1'b0;
        m_ovr = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        vt[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 8'h41};
        vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00};
        vt[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 8'h33};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00};
        vt[5] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1, 8'hC3};
        for (int i = 0; i < 6; i++) begin
            step(vt[i].iv, vt[i].d, vt[i].pp, vt[i].cl, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_count", i), int'(count),   vt[i].ecnt);
            chk($sformatf("vec%0d.tbl_rd", i),    int'(rd_data), int'(vt[i].erd));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        chk("fill.full", int'(full), 1);
        chk("fill.in_ready", int'(in_ready), 0);
        chk("fill.count", int'(count), 16);

        step(1'b1, 8'hAA, 1'b0, 1'b0, "drop_aa");
        chk("drop_aa.count", int'(count), 16);
        chk("drop_aa.overrun", int'(overrun), int'(OVR_EN));
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovr");
        chk("clr_ovr.overrun", int'(overrun), 0);
        step(1'b1, 8'hAB, 1'b0, 1'b1, "drop_and_clr");
        chk("drop_and_clr.overrun", int'(overrun), int'(OVR_EN));
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovr2");

        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("order%0d", i), int'(rd_data), i);
            step(1'b0, 8'h00, 1'b1, 1'b0, "pop_seq");
        end
        chk("order.empty", int'(data_avail), 0);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "refill");
        step(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
        chk("full_push_pop.count", int'(count), 15);
        seen55 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (rd_data == 8'h55) seen55 = 1'b1;
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain55");
        end
        chk("absent55", int'(seen55), 0);

        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "prewrap");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "wrap");
            if (count > 5'd16) chk("wrap.count_bound", int'(count), 16);
        end

        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = (i < 200) ? 3 : 1;
            step($urandom_range(0, 3) < pw, 8'($urandom), $urandom_range(0, 3) >= pw,
                 $urandom_range(0, 15) == 0, "rand");
        end

        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        mq.delete(); m_ovr = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "pre_rst");
        chk("pre_rst.count", int'(count), 5);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk_reset_outputs("async_rst");
        #0.5;
        rst_n = 1'b1;
        mq.delete(); m_ovr = 1'b0;
        step(1'b1, 8'h7E, 1'b0, 1'b0, "post_rst");
        chk("post_rst.rd", int'(rd_data), 8'h7E);
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
